fifo_sync_param: RTL and testbench

- Parametrised synchronous FIFO; next generation of the 6-bit lane FIFO.
- Adds generic width/depth, same-cycle read+write at full, registered read data with valid strobe, and hysteretic pause for upstream flow control.
- Adds sticky overflow/underflow error flags and an occupancy count.
- Sits between a lane producer and the consumer; pause goes back to the producer.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/fifo_mem_dp.sv | 33 +++
 rtl/fifo_sync_param.sv | 113 +++++++++++
 tb/tb_fifo_sync_param.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the lane FIFO family.
//   DEF_DATA_W  : default data word width
//   DEF_DEPTH   : default number of entries
//   LANE_DATA_W : lane data width shared with lane FIFO users
//   clog2()     : ceiling log2, used to derive pointer widths
package fifo_pkg;

  localparam int DEF_DATA_W  = 6;
  localparam int DEF_DEPTH   = 8;
  localparam int LANE_DATA_W = 6;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// Dual-port register array for the synchronous FIFO.
//   clk     : clock
//   wr_en   : write strobe, wr_data stored at wr_addr on the rising edge
//   wr_addr : write address
//   wr_data : write data
//   rd_en   : read strobe, rd_data loaded from rd_addr on the rising edge
//   rd_addr : read address
//   rd_data : registered read data (holds when rd_en is low)
// Neither the array nor the read register is reset.
module fifo_mem_dp #(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // A read and write to the same slot in one cycle returns the old word,
  // which is what a full FIFO doing read+write needs.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised synchronous FIFO with registered read data, hysteretic pause
// for upstream flow control, sticky error flags and occupancy count.
//   clk, RESET       : clock, asynchronous active-high reset
//   data_in, fifo_wr : write data and request
//   fifo_rd          : read request; data_out/valid_out one cycle later
//   al_empty_in      : almost-empty threshold, also pause release level
//   al_full_in       : almost-full threshold, also pause assert level
//   err_clr          : clears error_ovf and error_unf
//   data_out         : registered read data
//   valid_out        : data_out holds a word read at the last edge
//   fifo_empty/full  : count == 0 / count == DEPTH
//   al_empty/al_full : count <= al_empty_in / count >= al_full_in
//   pause            : back-pressure to producer
//   count            : occupancy
//   error_ovf/unf    : sticky dropped-write / read-on-empty flags
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                          clk,
  input  logic                          RESET,
  input  logic [DATA_W-1:0]             data_in,
  input  logic                          fifo_wr,
  input  logic                          fifo_rd,
  input  logic [fifo_pkg::clog2(DEPTH):0] al_empty_in,
  input  logic [fifo_pkg::clog2(DEPTH):0] al_full_in,
  input  logic                          err_clr,
  output logic [DATA_W-1:0]             data_out,
  output logic                          valid_out,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic                          al_empty,
  output logic                          al_full,
  output logic                          pause,
  output logic [fifo_pkg::clog2(DEPTH):0] count,
  output logic                          error_ovf,
  output logic                          error_unf
);

  localparam int ADDR_W = clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              rd_acc, wr_acc;
  logic [CNT_W-1:0]  count_next;
  logic [DATA_W-1:0] rd_data_p1;
  logic              dout_zero_p1;

  // Stage p0: access decisions from registered state and current requests
  always_comb begin
    rd_acc     = fifo_rd & ~fifo_empty;
    wr_acc     = fifo_wr & (~fifo_full | rd_acc);
    count_next = count + CNT_W'(wr_acc) - CNT_W'(rd_acc);
  end

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(DEPTH));
  assign al_empty   = (count <= al_empty_in);
  assign al_full    = (count >= al_full_in);

  fifo_mem_dp #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr),
    .rd_data (rd_data_p1)
  );

  // Stage p1: registered control state
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      valid_out    <= 1'b0;
      pause        <= 1'b0;
      error_ovf    <= 1'b0;
      error_unf    <= 1'b0;
      dout_zero_p1 <= 1'b1;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_acc) begin
        rd_ptr       <= rd_ptr + ADDR_W'(1);
        dout_zero_p1 <= 1'b0;
      end
      count     <= count_next;
      valid_out <= rd_acc;

      // Set wins over clear so misordered thresholds fail safe (paused).
      if (count_next >= al_full_in)       pause <= 1'b1;
      else if (count_next <= al_empty_in) pause <= 1'b0;

      if (err_clr)                 error_ovf <= 1'b0;
      else if (fifo_wr && !wr_acc) error_ovf <= 1'b1;

      if (err_clr)                     error_unf <= 1'b0;
      else if (fifo_rd && fifo_empty)  error_unf <= 1'b1;
    end
  end

  // The read register in the array has no reset; until the first read after
  // reset, data_out is forced to zero instead.
  assign data_out = dout_zero_p1 ? '0 : rd_data_p1;

endmodule

// File: tb/tb_fifo_sync_param.sv
module tb_fifo_sync_param;

  localparam int DATA_W = 6;
  localparam int DEPTH  = 8;
  localparam int CW     = 4;

  logic              clk = 1'b0;
  logic              RESET;
  logic [DATA_W-1:0] data_in;
  logic              fifo_wr, fifo_rd, err_clr;
  logic [CW-1:0]     al_empty_in, al_full_in;
  logic [DATA_W-1:0] data_out;
  logic              valid_out, fifo_empty, fifo_full, al_empty, al_full, pause;
  logic [CW-1:0]     count;
  logic              error_ovf, error_unf;

  fifo_sync_param #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .RESET       (RESET),
    .data_in     (data_in),
    .fifo_wr     (fifo_wr),
    .fifo_rd     (fifo_rd),
    .al_empty_in (al_empty_in),
    .al_full_in  (al_full_in),
    .err_clr     (err_clr),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full),
    .al_empty    (al_empty),
    .al_full     (al_full),
    .pause       (pause),
    .count       (count),
    .error_ovf   (error_ovf),
    .error_unf   (error_unf)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  string phase = "init";

  // Reference model: a queue of stored words plus the registered outputs.
  logic [DATA_W-1:0] mq[$];
  logic [DATA_W-1:0] m_dout;
  logic              m_vld, m_pause, m_ovf, m_unf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_dout = '0; m_vld = 1'b0; m_pause = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic check_all();
    int n;
    n = mq.size();
    chk("data_out",   32'(data_out),   32'(m_dout));
    chk("valid_out",  32'(valid_out),  32'(m_vld));
    chk("count",      32'(count),      32'(n));
    chk("fifo_empty", 32'(fifo_empty), 32'(n == 0));
    chk("fifo_full",  32'(fifo_full),  32'(n == DEPTH));
    chk("al_empty",   32'(al_empty),   32'(n <= int'(al_empty_in)));
    chk("al_full",    32'(al_full),    32'(n >= int'(al_full_in)));
    chk("pause",      32'(pause),      32'(m_pause));
    chk("error_ovf",  32'(error_ovf),  32'(m_ovf));
    chk("error_unf",  32'(error_unf),  32'(m_unf));
  endtask

  // One clock: apply requests, advance the model, check after the edge.
  task automatic cyc(input bit wr, input bit rd, input logic [DATA_W-1:0] d, input bit clr);
    bit empty, full, racc, wacc;
    int n;
    fifo_wr = wr; fifo_rd = rd; data_in = d; err_clr = clr;
    empty = (mq.size() == 0);
    full  = (mq.size() == DEPTH);
    racc  = rd && !empty;
    wacc  = wr && (!full || racc);
    if (racc) begin
      m_dout = mq.pop_front();
      m_vld  = 1'b1;
    end else begin
      m_vld  = 1'b0;
    end
    if (wacc) mq.push_back(d);
    n = mq.size();
    if (n >= int'(al_full_in))       m_pause = 1'b1;
    else if (n <= int'(al_empty_in)) m_pause = 1'b0;
    if (clr)              m_ovf = 1'b0;
    else if (wr && !wacc) m_ovf = 1'b1;
    if (clr)              m_unf = 1'b0;
    else if (rd && empty) m_unf = 1'b1;
    @(posedge clk);
    #1;
    check_all();
    fifo_wr = 1'b0; fifo_rd = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    RESET = 1'b1;
    data_in = '0; fifo_wr = 1'b0; fifo_rd = 1'b0; err_clr = 1'b0;
    al_empty_in = 4'd2; al_full_in = 4'd6;
    model_reset();

    // Reset state
    phase = "reset";
    #12;
    check_all();
    @(negedge clk);
    RESET = 1'b0;

    // Single write then read
    phase = "single";
    cyc(1, 0, 6'h12, 0);
    cyc(0, 1, '0, 0);
    chk("rd_data_12", 32'(data_out), 32'h12);
    cyc(0, 0, '0, 0);

    // Fill to full, overflow, then drain through the pause hysteresis
    phase = "fill";
    for (int i = 0; i < 8; i++) cyc(1, 0, 6'(i), 0);
    chk("full_flag", 32'(fifo_full), 32'd1);
    cyc(1, 0, 6'h09, 0);
    chk("ovf_set", 32'(error_ovf), 32'd1);
    phase = "drain";
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, '0, 0);
      chk("drain_order", 32'(data_out), 32'(i));
    end
    cyc(0, 0, '0, 1);

    // Read+write at full and at empty
    phase = "full_rw";
    for (int i = 0; i < 8; i++) cyc(1, 0, 6'($urandom_range(0, 62)), 0);
    cyc(1, 1, 6'h3F, 0);
    chk("full_rw_ovf", 32'(error_ovf), 32'd0);
    for (int i = 0; i < 8; i++) cyc(0, 1, '0, 0);
    chk("last_3f", 32'(data_out), 32'h3F);
    phase = "empty_rw";
    cyc(1, 1, 6'h15, 0);
    chk("empty_rw_unf", 32'(error_unf), 32'd1);
    cyc(0, 0, '0, 1);
    cyc(0, 1, '0, 0);

    // Interleaved traffic across several pointer wraps
    phase = "interleave";
    for (int i = 0; i < 60; i++)
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom), 0);

    // Random traffic with moving thresholds and occasional error clears
    phase = "random";
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        al_empty_in = 4'($urandom_range(0, DEPTH));
        al_full_in  = 4'($urandom_range(0, DEPTH));
      end
      cyc(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0),
          6'($urandom), $urandom_range(0, 19) == 0);
    end
    al_empty_in = 4'd2; al_full_in = 4'd6;

    // Asynchronous reset mid-burst
    phase = "async_rst";
    for (int i = 0; i < 7; i++) cyc(1, i > 2, 6'($urandom), 0);
    #2;
    RESET = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    RESET = 1'b0;
    cyc(1, 0, 6'h2A, 0);
    cyc(0, 1, '0, 0);
    chk("post_rst_data", 32'(data_out), 32'h2A);
    cyc(0, 0, '0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
